seg7_capture: RTL
=================

SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 The module SHALL have one clock, clk_50MHz, and reset, a synchronous, active-high reset.
REQ-002 Parameter STABLE_CYCLES, default 16, SHALL set the clocks that digit and seg must hold unchanged before a sample is taken (range 2..255).
REQ-003 Parameter TIMEOUT_CYCLES, default 1048576, SHALL set the clocks without any capture before stale asserts.
REQ-004 Ports SHALL be as follows, one per line:
- clk_50MHz  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- seg  in  8  segment bus, active-low; [7]=dp (ignored), [6:0]=g,f,e,d,c,b,a.
- digit  in  4  anodes, active-low; digit[0]=ones, [1]=tens, [2]=hundreds, [3]=unused position.
- bcd  out  12  last good frame, {hundreds,tens,ones}.
- value  out  10  binary equivalent of bcd.
- frame_valid  out  1  one-cycle pulse on each good frame.
- pattern_err  out  1  one-cycle pulse on each frame containing an undecodable digit.
- stale  out  1  level; high while no capture has occurred for TIMEOUT_CYCLES.

Function
REQ-005 The anode pattern SHALL be valid only when exactly one bit of digit is 0; any other pattern (all 1s, two or more 0s) is invalid.
REQ-006 The FSM SHALL have states SCAN, SETTLE and HOLD.
REQ-007 SCAN SHALL move to SETTLE on a valid pattern and clear the stability counter.
REQ-008 In SETTLE, the counter SHALL increment each clock in which {digit,seg} equals the previous clock's value.
REQ-009 In SETTLE, any change in {digit,seg} SHALL clear the counter and keep SETTLE if the new pattern is valid, or go to SCAN if it is invalid.
REQ-010 When the counter reaches STABLE_CYCLES-1 on a clock edge, the current seg SHALL be sampled for the active position and the FSM SHALL enter HOLD.
REQ-011 HOLD SHALL go to SETTLE (counter cleared) when digit changes to another valid pattern, to SCAN when digit becomes invalid, and SHALL ignore seg changes.
REQ-012 Decoding of seg[6:0] SHALL be: 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x10→9, 0x7F (blank)→0.
REQ-013 Any other seg[6:0] code SHALL mark that position's digit as bad.
REQ-014 Samples at positions 0..2 SHALL write a per-position nibble and a bad flag, and set that position's bit in a 3-bit capture mask.
REQ-015 Samples at position 3 SHALL be discarded, SHALL NOT change the mask, and SHALL still count as a capture for the stale timer.
REQ-016 Resampling a position already in the mask SHALL overwrite its nibble and bad flag.
REQ-017 On the edge where the mask becomes 3'b111 with no bad flag set, bcd and value SHALL update, and frame_valid SHALL be 1 for exactly the following cycle.
REQ-018 On the edge where the mask becomes 3'b111 with any bad flag set, pattern_err SHALL pulse for one cycle, and bcd, value and frame_valid SHALL be unchanged.
REQ-019 In either frame-completion case, the mask and bad flags SHALL clear on the same edge.
REQ-020 value SHALL equal hundreds*100 + tens*10 + ones (0..999), computed as unsigned with no truncation.
REQ-021 The stale counter SHALL clear on every capture and otherwise increment, saturating at TIMEOUT_CYCLES.
REQ-022 stale SHALL be 1 while the stale counter equals TIMEOUT_CYCLES and SHALL drop on the clock after the next capture.
REQ-023 frame_valid and pattern_err SHALL never be high in the same cycle.

Reset
REQ-024 While reset=1 at a clock edge: state→SCAN; counters, mask and bad flags→0; bcd→12'h000; value→0; frame_valid→0; pattern_err→0; stale→0.
REQ-025 Reset asserted mid-frame SHALL discard partial captures; the first frame after reset needs fresh samples at all three positions.
REQ-026 Reset SHALL take priority over every other event on the same edge.

Verification
REQ-027 Scan digit=1110/1101/1011 with seg=0x12/0x30/0x79, each held 20 clocks -> frame_valid pulse; bcd=12'h135, value=135.
REQ-028 As REQ-027, but toggle seg every 8 clocks on position 0 for 40 clocks, then hold 0x40 for 20 clocks -> no capture during toggling; final bcd=12'h130.
REQ-029 Position 1 driven with seg=0x7E (undecodable), others valid -> pattern_err pulse; frame_valid stays 0; bcd holds its prior value.
REQ-030 digit=1100 for 100 clocks, then blank at all positions, then digit=0111 with seg=0x00 -> no captures and no mask change; value remains 0.
REQ-031 TIMEOUT_CYCLES=64 with digit=1111 held -> stale=1 at clock 64; one valid capture -> stale=0 on the following clock.
REQ-032 Reset pulsed after positions 0 and 1 are captured, then only position 2 is scanned -> no frame_valid until all three positions are rescanned.

Source files
------------

// File: rtl/seg7_capture.sv
// ---------------------------------------------------------------------------
// seg7_capture
//   Snoops a multiplexed, active-low 7-segment display bus and reconstructs
//   the three-digit decimal number being shown. Each anode position has to
//   hold a stable {digit,seg} pattern for STABLE_CYCLES clocks before its
//   segment code is sampled. Once all three positions are sampled, the frame
//   is published as BCD and binary, or flagged if any position was
//   undecodable.
//
// Ports
//   clk_50MHz    in   1   system clock
//   reset        in   1   synchronous, active-high reset
//   seg          in   8   segments, active-low; [7]=dp, [6:0]=g,f,e,d,c,b,a
//   digit        in   4   anodes, active-low; [0]=ones [1]=tens [2]=hundreds
//                         [3]=unused position
//   bcd          out  12  last good frame {hundreds,tens,ones}
//   value        out  10  binary equivalent of bcd (0..999)
//   frame_valid  out  1   one-cycle pulse per good frame
//   pattern_err  out  1   one-cycle pulse per frame with an undecodable digit
//   stale        out  1   high while no capture for TIMEOUT_CYCLES clocks
// ---------------------------------------------------------------------------
module seg7_capture #(
   parameter int STABLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic        clk_50MHz,
   input  logic        reset,
   input  logic [7:0]  seg,
   input  logic [3:0]  digit,
   output logic [11:0] bcd,
   output logic [9:0]  value,
   output logic        frame_valid,
   output logic        pattern_err,
   output logic        stale
);

   localparam logic [1:0] SCAN   = 2'd0;
   localparam logic [1:0] SETTLE = 2'd1;
   localparam logic [1:0] HOLD   = 2'd2;

   localparam int          SW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [SW-1:0] STALE_MAX = SW'(TIMEOUT_CYCLES);
   localparam logic [7:0]  CNT_LAST  = 8'(STABLE_CYCLES - 1);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [1:0]       state_q;
   logic [7:0]       cnt_q;
   logic [11:0]      prev_q;
   logic [2:0][3:0]  nib_q;
   logic [2:0]       bad_q;
   logic [2:0]       mask_q;
   logic [11:0]      bcd_q;
   logic [9:0]       value_q;
   logic             fv_q;
   logic             pe_q;
   logic [SW-1:0]    stale_cnt_q;

   // ------------------------------------------------------------------
   // Input qualification
   // ------------------------------------------------------------------
   logic [11:0] cur;
   logic        pat_valid;
   logic [1:0]  pos;
   logic        same_pat;
   logic        digit_changed;

   assign cur           = {digit, seg};
   assign same_pat      = (cur == prev_q);
   assign digit_changed = (digit != prev_q[11:8]);

   // Exactly one anode low selects a position; anything else is noise or
   // blanking between scan steps.
   always_comb begin
      pat_valid = 1'b1;
      pos       = 2'd0;
      case (digit)
         4'b1110: pos = 2'd0;
         4'b1101: pos = 2'd1;
         4'b1011: pos = 2'd2;
         4'b0111: pos = 2'd3;
         default: pat_valid = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------
   // Segment decoder (dp ignored, blank reads as zero)
   // ------------------------------------------------------------------
   logic [3:0] dec_val;
   logic       dec_bad;

   always_comb begin
      dec_val = 4'd0;
      dec_bad = 1'b0;
      case (seg[6:0])
         7'h40: dec_val = 4'd0;
         7'h79: dec_val = 4'd1;
         7'h24: dec_val = 4'd2;
         7'h30: dec_val = 4'd3;
         7'h19: dec_val = 4'd4;
         7'h12: dec_val = 4'd5;
         7'h02: dec_val = 4'd6;
         7'h78: dec_val = 4'd7;
         7'h00: dec_val = 4'd8;
         7'h10: dec_val = 4'd9;
         7'h7F: dec_val = 4'd0;
         default: dec_bad = 1'b1;
      endcase
   end

   // ------------------------------------------------------------------
   // Settle FSM
   // ------------------------------------------------------------------
   logic [1:0] state_d;
   logic [7:0] cnt_d;
   logic       sample;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sample  = 1'b0;
      case (state_q)
         SCAN: begin
            if (pat_valid) begin
               state_d = SETTLE;
               cnt_d   = '0;
            end
         end
         SETTLE: begin
            if (!same_pat) begin
               cnt_d = '0;
               if (!pat_valid)
                  state_d = SCAN;
            end else if (cnt_q + 8'd1 == CNT_LAST) begin
               // The edge on which the counter would reach its last value
               // is the STABLE_CYCLES-th edge seeing this pattern.
               sample  = 1'b1;
               state_d = HOLD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         HOLD: begin
            // Only anode movement matters here; segment flicker within the
            // same position is deliberately ignored.
            if (digit_changed) begin
               cnt_d   = '0;
               state_d = pat_valid ? SETTLE : SCAN;
            end
         end
         default: begin
            state_d = SCAN;
            cnt_d   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Frame assembly
   // ------------------------------------------------------------------
   logic             store;
   logic [2:0][3:0]  nib_d;
   logic [2:0]       bad_d;
   logic [2:0]       mask_d;
   logic             frame_done;
   logic             frame_good;
   logic [9:0]       hun_x100;
   logic [9:0]       ten_x10;
   logic [9:0]       value_d;

   // Position 3 samples count as activity but never touch the frame.
   assign store = sample && (pos != 2'd3);

   always_comb begin
      nib_d  = nib_q;
      bad_d  = bad_q;
      mask_d = mask_q;
      if (store) begin
         nib_d[pos]  = dec_val;
         bad_d[pos]  = dec_bad;
         mask_d[pos] = 1'b1;
      end
   end

   assign frame_done = store && (mask_d == 3'b111);
   assign frame_good = frame_done && (bad_d == 3'b000);

   // Nibbles are decoded digits (<= 9) whenever the frame is good, so the
   // sum never exceeds 999 and fits the 10-bit result.
   assign hun_x100 = 10'(nib_d[2]) * 10'd100;
   assign ten_x10  = 10'(nib_d[1]) * 10'd10;
   assign value_d  = hun_x100 + ten_x10 + 10'(nib_d[0]);

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk_50MHz) begin
      if (reset) begin
         state_q     <= SCAN;
         cnt_q       <= '0;
         prev_q      <= '1;
         nib_q       <= '0;
         bad_q       <= '0;
         mask_q      <= '0;
         bcd_q       <= '0;
         value_q     <= '0;
         fv_q        <= 1'b0;
         pe_q        <= 1'b0;
         stale_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prev_q  <= cur;
         nib_q   <= nib_d;

         if (frame_done) begin
            mask_q <= '0;
            bad_q  <= '0;
         end else begin
            mask_q <= mask_d;
            bad_q  <= bad_d;
         end

         if (frame_good) begin
            bcd_q   <= {nib_d[2], nib_d[1], nib_d[0]};
            value_q <= value_d;
         end

         fv_q <= frame_good;
         pe_q <= frame_done && !frame_good;

         if (sample)
            stale_cnt_q <= '0;
         else if (stale_cnt_q != STALE_MAX)
            stale_cnt_q <= stale_cnt_q + 1'b1;
      end
   end

   assign bcd         = bcd_q;
   assign value       = value_q;
   assign frame_valid = fv_q;
   assign pattern_err = pe_q;
   assign stale       = (stale_cnt_q == STALE_MAX);

endmodule
